// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target with a register-addressed protocol. A write sets the
// register pointer and then streams data bytes; a read after a repeated START returns
// bytes fetched through a single-cycle register-bank port.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wdata,
  output logic       o_wr,
  output logic       o_rd,
  input  logic [7:0] i_rdata,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StDevAck,
    StRegAddr,
    StRegAck,
    StWdata,
    StWrAck,
    StRdLoad,
    StRdata,
    StMack
  } state_e;

  // Input conditioning: 2-FF synchronizer, then majority of three consecutive samples.
  logic [1:0] scl_sync, sda_sync;
  logic [1:0] scl_hist, sda_hist;
  logic       scl_f, sda_f, scl_prev, sda_prev;
  logic       scl_maj, sda_maj;

  assign scl_maj = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                   (scl_hist[0] & scl_hist[1]);
  assign sda_maj = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                   (sda_hist[0] & sda_hist[1]);

  // Synchronize and filter the bus lines; reset to the idle (high) bus level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= scl_maj;
      sda_f    <= sda_maj;
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_f & ~scl_prev;
  assign scl_fall   = ~scl_f & scl_prev;
  assign start_cond = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_cond  = scl_f & scl_prev & ~sda_prev & sda_f;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;

  logic rx_shift, byte_done;
  assign rx_shift  = scl_rise && (state_q inside {StDevAddr, StRegAddr, StWdata});
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  // Protocol state register and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      ptr_q     <= 8'h00;
      wdata_q   <= 8'h00;
      sda_oe_q  <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      sda_oe_q  <= sda_oe_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, shift register, pointer and strobe logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    sda_oe_d  = sda_oe_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    busy_d    = busy_q;

    // Write pointer advances the cycle after the write strobe.
    if (wr_q && AUTO_INC) ptr_d = ptr_q + 8'd1;

    if (rx_shift) begin
      shreg_d   = {shreg_q[6:0], sda_f};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: ;
      StDevAddr: begin
        if (byte_done) begin
          bit_cnt_d = 4'd0;
          if (shreg_q[7:1] == SLAVE_ADDR) begin
            state_d  = StDevAck;
            sda_oe_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRegAddr: begin
        if (byte_done) begin
          bit_cnt_d = 4'd0;
          ptr_d     = shreg_q;
          state_d   = StRegAck;
          sda_oe_d  = 1'b1;
        end
      end
      StWdata: begin
        if (rx_shift && bit_cnt_q == 4'd7) begin
          wr_d    = 1'b1;
          wdata_d = {shreg_q[6:0], sda_f};
        end
        if (byte_done) begin
          bit_cnt_d = 4'd0;
          state_d   = StWrAck;
          sda_oe_d  = 1'b1;
        end
      end
      StDevAck: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          // shreg still holds the address byte; bit 0 is R/W.
          if (shreg_q[0]) begin
            state_d = StRdLoad;
            rd_d    = 1'b1;
          end else begin
            state_d = StRegAddr;
          end
        end
      end
      StRegAck, StWrAck: begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = StWdata;
        end
      end
      StRdLoad: begin
        // Strobe cycle first, then capture the returned data on the following cycle.
        if (!rd_q) begin
          shreg_d   = i_rdata;
          sda_oe_d  = ~i_rdata[7];
          bit_cnt_d = 4'd0;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = StMack;
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
      end
      StMack: begin
        // bit_cnt marks that the master ACKed; the next byte is fetched on the falling edge.
        if (scl_rise) begin
          if (sda_f) begin
            state_d = StIdle;
          end else begin
            bit_cnt_d = 4'd1;
            if (AUTO_INC) ptr_d = ptr_q + 8'd1;
          end
        end else if (scl_fall && bit_cnt_q == 4'd1) begin
          bit_cnt_d = 4'd0;
          rd_d      = 1'b1;
          state_d   = StRdLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    if (stop_cond) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end
    if (start_cond) begin
      state_d   = StDevAddr;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end

    // Busy holds across repeated START and clears whenever the block falls back to idle.
    if (state_d == StIdle) begin
      busy_d = 1'b0;
    end else if (state_d == StDevAck) begin
      busy_d = 1'b1;
    end
  end

  assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
  assign o_reg_addr = ptr_q;
  assign o_wdata    = wdata_q;
  assign o_wr       = wr_q;
  assign o_rd       = rd_q;
  assign o_busy     = busy_q;

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) for the register-addressed transaction format issued by the team's I2C master.
- Decodes START/STOP and a 7-bit device address, then either accepts a register-address byte followed by write data, or returns read data after a repeated START.
- Exposes a simple single-cycle register-bank port so that FPGA-side registers can be reached from an I2C master on the PI4 header.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address this block responds to.
- AUTO_INC, 1, 1 = register pointer increments after every data byte (write or read); 0 = pointer holds.

Ports:
- i_clk  input  1  system clock; must be at least 20x SCL.
- i_rst  input  1  synchronous, active-high reset.
- SCL  input  1  I2C clock (no clock stretching).
- SDA  inout  1  I2C data; driven low only, otherwise 1'bz.
- o_reg_addr  output  8  current register pointer.
- o_wdata  output  8  write data; valid when o_wr=1.
- o_wr  output  1  one-cycle write strobe.
- o_rd  output  1  one-cycle read strobe; i_rdata is sampled on the next cycle.
- i_rdata  input  8  read data for o_reg_addr.
- o_busy  output  1  high from an address-matched START until STOP or NACK.

Behaviour:
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer plus a 3-sample majority filter.
  - Edges are detected on the filtered signals.
  - Pin-to-internal latency is 4 cycles.
- Bus conditions (on filtered signals):
  - START = SDA falling while SCL high. It is valid in every state, including mid-byte, and forces DEV_ADDR with bit count 0.
  - STOP = SDA rising while SCL high. It forces IDLE and releases SDA.
- Bit timing:
  - SDA is sampled on SCL rising.
  - SDA drive changes only on SCL falling.
  - Bits are MSB first; a 4-bit counter runs 0..8, with the 9th bit being ACK.
- States and transitions:
  - IDLE: SDA released, o_busy=0.
  - DEV_ADDR: shift in 8 bits.
    - If bits[7:1] != SLAVE_ADDR, go to IDLE (no ACK; wait for the next START).
    - Else if R/W=0, go to DEV_ACK then REG_ADDR.
    - Else if R/W=1, go to DEV_ACK then RD_LOAD.
  - DEV_ACK / REG_ACK / WR_ACK: pull SDA low from the SCL falling edge after bit 8 until the SCL falling edge after the ACK bit.
  - REG_ADDR: shift in 8 bits, load the pointer, go to REG_ACK, then WDATA.
  - WDATA: shift in 8 bits.
    - On the SCL rising edge of bit 8, pulse o_wr for 1 cycle with o_wdata = the received byte.
    - Go to WR_ACK, then WDATA again.
    - The pointer increments one cycle after o_wr when AUTO_INC=1.
  - RD_LOAD: on the SCL falling edge ending the ACK bit, pulse o_rd.
    - On the next cycle, latch i_rdata into the shift register and drive the MSB.
    - Go to RDATA.
  - RDATA:
    - Drive SDA low for 0 bits and release it for 1 bits, updating on each SCL falling edge.
    - After 8 bits, release SDA and go to MACK.
  - MACK: sample SDA on SCL rising.
    - 0 (ACK): increment the pointer if AUTO_INC=1, then go to RD_LOAD.
    - 1 (NACK): go to IDLE.
- o_busy: 1 from DEV_ACK through any state except IDLE.
- Reset values (i_rst held high for one or more cycles, taking effect on the i_clk edge):
  - State = IDLE, SDA released, pointer = 8'h00.
  - o_wdata = 0, o_wr = 0, o_rd = 0, o_busy = 0.
- Reset mid-transfer: SDA is released within 1 cycle; the block ignores the bus until the next START.
- Pointer width: 8 bits, wrapping 8'hFF -> 8'h00.
- A write transaction with no data bytes (START, address, register, STOP) only sets the pointer. It is used to pre-set the pointer for a following read.
- STOP during WDATA before bit 8 discards the partial byte; no o_wr is issued.

Test Plan:
- Write: START, 0xA0, 0x12, 0x5A, STOP -> 3 ACKs; exactly one o_wr with o_reg_addr=0x12 and o_wdata=0x5A; o_busy falls after STOP.
- Read: START, 0xA0, 0x34, repeated START, 0xA1, master NACK, STOP, with i_rdata=0xC3 -> ACK on 0xA0, 0x34 and 0xA1; o_rd with o_reg_addr=0x34; SDA bits 1100_0011; state IDLE after NACK.
- Burst with AUTO_INC=1: write 0xFE, then data 0x01, 0x02, 0x03 -> o_wr at addresses 0xFE, 0xFF, 0x00 (wrap); a burst read of 3 bytes with master ACK, ACK, NACK -> o_rd at 3 consecutive addresses.
- Address mismatch: START, 0xA2 -> SDA never driven, no o_wr/o_rd, o_busy stays 0; a following valid transaction still succeeds.
- Abort: STOP after 4 bits of WDATA -> no o_wr; START mid-RDATA -> SDA released at once and the block re-enters DEV_ADDR.
- Reset: assert i_rst during DEV_ACK with SDA driven low -> SDA released within 1 cycle, all outputs 0, pointer 0x00.
